// File: rtl/dataplane_pkg.sv
// Shared dataplane constants, TX framer state encoding and small helpers.
package dataplane_pkg;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
  localparam int          TX_HDR_BYTES  = 42;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CSUM  = 3'd1,
    HDR   = 3'd2,
    MERGE = 3'd3,
    FLUSH = 3'd4
  } tx_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/ip_csum.sv
// Combinational IPv4 header checksum over ten 16-bit words; the caller
// supplies the checksum field itself as zero.
module ip_csum (
  input  logic [159:0] words,
  output logic [15:0]  csum
);

  logic [19:0] sum_s;
  logic [16:0] fold1_s;
  logic [15:0] fold2_s;

  // Wide sum, then two end-around carry folds and inversion.
  always_comb begin
    sum_s = 20'd0;
    for (int i = 0; i < 10; i++) begin
      sum_s = sum_s + {4'd0, words[16*i +: 16]};
    end
    fold1_s = {1'b0, sum_s[15:0]} + {13'd0, sum_s[19:16]};
    fold2_s = fold1_s[15:0] + {15'd0, fold1_s[16]};
    csum    = ~fold2_s;
  end

endmodule

// File: rtl/udp_tx_framer.sv
// Builds Ethernet/IPv4/UDP frames: 42-byte header followed by the payload
// shifted by two bytes onto a 64-bit AXI-Stream master.
module udp_tx_framer
  import dataplane_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TTL        = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  input  logic [47:0]             dst_mac,
  input  logic [47:0]             src_mac,
  input  logic [31:0]             src_ip,
  input  logic [31:0]             dst_ip,
  input  logic [15:0]             src_port,
  input  logic [15:0]             dst_port,
  input  logic [15:0]             payload_len,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tlast,
  output logic                    len_err
);

  localparam logic [7:0] TTL_BYTE = 8'(TTL);

  tx_state_e state_r, state_s;
  logic [2:0]  hdr_cnt_r, hdr_cnt_s;
  logic [15:0] residue_r, residue_s;
  logic [7:0]  flush_keep_r, flush_keep_s;
  logic [15:0] byte_cnt_r, byte_cnt_s;
  logic        busy_r, busy_s;
  logic [15:0] ident_r, ident_s;
  logic [DATA_WIDTH-1:0]   m_tdata_r, m_tdata_s;
  logic [DATA_WIDTH/8-1:0] m_tkeep_r, m_tkeep_s;
  logic        m_tvalid_r, m_tvalid_s, m_tlast_r, m_tlast_s;
  logic        len_err_r, len_err_s, s_tready_s;

  logic [47:0] dst_mac_r, src_mac_r;
  logic [31:0] src_ip_r, dst_ip_r;
  logic [15:0] src_port_r, dst_port_r, payload_len_r, csum_r;

  logic        accept_s, ld_s;
  logic [3:0]  n_s;
  logic [15:0] cnt_sum_s, total_len_s, udp_len_s, csum_s;
  logic [8:0]  last_mask_s;
  logic [TX_HDR_BYTES*8-1:0] hdr_be_s;
  logic [63:0] hdr_beat_s;

  assign accept_s    = start && !busy_r && (state_r == IDLE);
  assign ld_s        = !m_tvalid_r || m_tready;
  assign n_s         = popcount8(s_tkeep);
  assign cnt_sum_s   = byte_cnt_r + {12'd0, n_s};
  assign last_mask_s = (9'd1 << (n_s + 4'd2)) - 9'd1;
  assign total_len_s = payload_len_r + 16'd28;
  assign udp_len_s   = payload_len_r + 16'd8;

  ip_csum u_ip_csum (
    .words ({16'h4500, total_len_s, ident_r, 16'h4000, TTL_BYTE, IP_PROTO_UDP,
             16'h0000, src_ip_r, dst_ip_r}),
    .csum  (csum_s)
  );

  // Header in wire order: frame byte 0 is the most significant byte here.
  assign hdr_be_s = {dst_mac_r, src_mac_r, ETH_TYPE_IPV4, 8'h45, 8'h00, total_len_s,
                     ident_r, 16'h4000, TTL_BYTE, IP_PROTO_UDP, csum_r, src_ip_r,
                     dst_ip_r, src_port_r, dst_port_r, udp_len_s, 16'h0000};

  // Pick the eight header bytes of the current header beat.
  always_comb begin
    hdr_beat_s = 64'd0;
    for (int k = 0; k < 8; k++) begin
      hdr_beat_s[8*k +: 8] = hdr_be_s[TX_HDR_BYTES*8 - 1 - 8*(8*int'(hdr_cnt_r) + k) -: 8];
    end
  end

  // Next-state and next-output logic for the framer.
  always_comb begin
    state_s      = state_r;
    hdr_cnt_s    = hdr_cnt_r;
    residue_s    = residue_r;
    flush_keep_s = flush_keep_r;
    byte_cnt_s   = byte_cnt_r;
    busy_s       = busy_r;
    ident_s      = ident_r;
    m_tdata_s    = m_tdata_r;
    m_tkeep_s    = m_tkeep_r;
    m_tvalid_s   = m_tvalid_r;
    m_tlast_s    = m_tlast_r;
    len_err_s    = 1'b0;
    s_tready_s   = 1'b0;
    if (m_tvalid_r && m_tready) begin
      m_tvalid_s = 1'b0;
      if (m_tlast_r) begin
        busy_s  = 1'b0;
        ident_s = ident_r + 16'd1;
      end else begin
        busy_s  = busy_r;
      end
    end else begin
      m_tvalid_s = m_tvalid_r;
    end
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s   = CSUM;
          busy_s    = 1'b1;
          hdr_cnt_s = 3'd0;
        end else begin
          state_s   = IDLE;
        end
      end
      CSUM: begin
        // Beat 0 carries only MACs, so it goes out while the checksum registers.
        m_tdata_s  = hdr_beat_s;
        m_tkeep_s  = 8'hFF;
        m_tlast_s  = 1'b0;
        m_tvalid_s = 1'b1;
        hdr_cnt_s  = 3'd1;
        state_s    = HDR;
      end
      HDR: begin
        if (ld_s) begin
          m_tdata_s  = hdr_beat_s;
          m_tkeep_s  = 8'hFF;
          m_tlast_s  = 1'b0;
          m_tvalid_s = 1'b1;
          if (hdr_cnt_r == 3'd4) begin
            state_s    = MERGE;
            residue_s  = {hdr_be_s[7:0], hdr_be_s[15:8]};
            byte_cnt_s = 16'd0;
          end else begin
            hdr_cnt_s  = hdr_cnt_r + 3'd1;
          end
        end else begin
          state_s = HDR;
        end
      end
      MERGE: begin
        s_tready_s = ld_s;
        if (s_tvalid && ld_s) begin
          m_tdata_s  = {s_tdata[47:0], residue_r};
          m_tkeep_s  = 8'hFF;
          m_tlast_s  = 1'b0;
          m_tvalid_s = 1'b1;
          residue_s  = s_tdata[63:48];
          byte_cnt_s = cnt_sum_s;
          if (s_tlast) begin
            len_err_s = (cnt_sum_s != payload_len_r);
            if (n_s <= 4'd6) begin
              m_tkeep_s = last_mask_s[7:0];
              m_tlast_s = 1'b1;
              state_s   = IDLE;
            end else begin
              flush_keep_s = (n_s == 4'd7) ? 8'h01 : 8'h03;
              state_s      = FLUSH;
            end
          end else begin
            state_s = MERGE;
          end
        end else begin
          state_s = MERGE;
        end
      end
      FLUSH: begin
        if (ld_s) begin
          m_tdata_s  = (flush_keep_r == 8'h01) ? {56'd0, residue_r[7:0]} : {48'd0, residue_r};
          m_tkeep_s  = flush_keep_r;
          m_tlast_s  = 1'b1;
          m_tvalid_s = 1'b1;
          state_s    = IDLE;
        end else begin
          state_s = FLUSH;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Framer state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      hdr_cnt_r    <= 3'd0;
      residue_r    <= 16'd0;
      flush_keep_r <= 8'd0;
      byte_cnt_r   <= 16'd0;
      busy_r       <= 1'b0;
      ident_r      <= 16'd0;
      m_tdata_r    <= 64'd0;
      m_tkeep_r    <= 8'd0;
      m_tvalid_r   <= 1'b0;
      m_tlast_r    <= 1'b0;
      len_err_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      hdr_cnt_r    <= hdr_cnt_s;
      residue_r    <= residue_s;
      flush_keep_r <= flush_keep_s;
      byte_cnt_r   <= byte_cnt_s;
      busy_r       <= busy_s;
      ident_r      <= ident_s;
      m_tdata_r    <= m_tdata_s;
      m_tkeep_r    <= m_tkeep_s;
      m_tvalid_r   <= m_tvalid_s;
      m_tlast_r    <= m_tlast_s;
      len_err_r    <= len_err_s;
    end
  end

  // Header fields captured on accept; checksum registered in CSUM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_mac_r     <= 48'd0;
      src_mac_r     <= 48'd0;
      src_ip_r      <= 32'd0;
      dst_ip_r      <= 32'd0;
      src_port_r    <= 16'd0;
      dst_port_r    <= 16'd0;
      payload_len_r <= 16'd0;
      csum_r        <= 16'd0;
    end else begin
      if (accept_s) begin
        dst_mac_r     <= dst_mac;
        src_mac_r     <= src_mac;
        src_ip_r      <= src_ip;
        dst_ip_r      <= dst_ip;
        src_port_r    <= src_port;
        dst_port_r    <= dst_port;
        payload_len_r <= payload_len;
      end
      if (state_r == CSUM) begin
        csum_r <= csum_s;
      end
    end
  end

  assign busy     = busy_r;
  assign s_tready = s_tready_s;
  assign m_tvalid = m_tvalid_r;
  assign m_tdata  = m_tdata_r;
  assign m_tkeep  = m_tkeep_r;
  assign m_tlast  = m_tlast_r;
  assign len_err  = len_err_r;

endmodule
